// File: rtl/cnt_pkg.sv
// Shared constants for the up/down counter family: saturation mode
// selectors and the common modulus values.
package cnt_pkg;

   // Behaviour at terminal count
   localparam int MODE_WRAP = 0;   // roll over to the opposite end
   localparam int MODE_SAT  = 1;   // hold at terminal count, flag sat

   // Frequently used moduli
   localparam int DECADE  = 10;
   localparam int BINARY4 = 16;

endpackage : cnt_pkg

// File: rtl/updn_counter.sv
// Synchronous modulo-N up/down counter with load, clear, dual count
// enables (ent/enp), combinational ripple carry for cascading, a
// registered wrap pulse and a registered saturation flag.
module updn_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 2**WIDTH,
   parameter int SATURATE  = MODE_WRAP,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] p,
   input  logic             ent,
   input  logic             enp,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             rco,
   output logic             wrap,
   output logic             sat
);

   localparam int               WP1     = WIDTH + 1;
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   // One bit wider so MODULUS == 2**WIDTH is representable
   localparam logic [WIDTH:0]   MOD_EXT = WP1'(MODULUS);
   localparam bit               SAT_EN  = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] q_reg;
   logic             wrap_reg;
   logic             sat_reg;

   logic             at_max;
   logic             at_zero;
   logic             tc;
   logic             count_en;
   logic [WIDTH-1:0] p_clamped;
   logic [WIDTH-1:0] q_up;
   logic [WIDTH-1:0] q_dn;

   assign at_max   = (q_reg == MAX_Q);
   assign at_zero  = (q_reg == '0);

   // Terminal count in the current direction; rco is purely combinational
   // so a cascade of stages advances on the same edge.
   assign tc       = up ? at_max : at_zero;
   assign rco      = ent & tc;

   // load and clr both pre-empt counting
   assign count_en = ent & enp & ~load & ~clr;

   // Out-of-range preset values are clamped to the top of the range
   assign p_clamped = ({1'b0, p} >= MOD_EXT) ? MAX_Q : p;

   // Wrapped single steps; never leave the 0..MODULUS-1 range
   assign q_up = at_max  ? '0    : q_reg + ONE;
   assign q_dn = at_zero ? MAX_Q : q_reg - ONE;

   // Count state: priority rst > clr > load > count > hold
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q_reg    <= RST_Q;
         wrap_reg <= 1'b0;
         sat_reg  <= 1'b0;
      end else if (load) begin
         q_reg    <= p_clamped;
         wrap_reg <= 1'b0;
         sat_reg  <= 1'b0;
      end else if (count_en) begin
         if (tc && SAT_EN) begin
            // Blocked at the end of the range: hold and flag it
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b1;
         end else begin
            q_reg    <= up ? q_up : q_dn;
            wrap_reg <= tc;
            sat_reg  <= 1'b0;
         end
      end else begin
         wrap_reg <= 1'b0;
      end
   end

   assign q    = q_reg;
   assign wrap = wrap_reg;
   assign sat  = sat_reg;

endmodule : updn_counter

// File: tb/tb_updn_counter.sv
// Self-checking bench for updn_counter: six instances covering decade,
// binary, saturating, 8-bit and a two-digit decade cascade, driven by
// directed sequences then random stimulus, against an arithmetic model.
module tb_updn_counter;

   localparam int N = 6;
   // Instance order: lo, hi, bin, bin_sat, b8, dec_sat
   int mod_a [N] = '{10, 10, 16, 16, 256, 10};
   int sm_a  [N] = '{0, 0, 0, 1, 0, 1};
   int rv_a  [N] = '{0, 0, 0, 3, 0, 5};
   int wd_a  [N] = '{4, 4, 4, 4, 8, 4};

   logic       clk = 1'b0;
   logic       rst = 1'b0, clr = 1'b0, load = 1'b0;
   logic       ent = 1'b0, enp = 1'b0, up = 1'b1;
   logic [7:0] p = '0;

   logic [3:0] q_lo, q_hi, q_bin, q_bsat, q_dsat;
   logic [7:0] q_b8;
   logic       rco_lo, rco_hi, rco_bin, rco_bsat, rco_b8, rco_dsat;
   logic       wrap_lo, wrap_hi, wrap_bin, wrap_bsat, wrap_b8, wrap_dsat;
   logic       sat_lo, sat_hi, sat_bin, sat_bsat, sat_b8, sat_dsat;

   logic [31:0] oq [N];
   logic        orc[N], ow[N], os[N];

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   bit  mvalid = 1'b0;
   int  mq [N];
   bit  mw [N], ms [N];
   bit  exp_rco [N];

   always #5 clk = ~clk;

   updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_lo (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p[3:0]), .ent(ent), .enp(enp),
      .up(up), .q(q_lo), .rco(rco_lo), .wrap(wrap_lo), .sat(sat_lo));
   updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_hi (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p[3:0]), .ent(rco_lo), .enp(enp),
      .up(up), .q(q_hi), .rco(rco_hi), .wrap(wrap_hi), .sat(sat_hi));
   updn_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_bin (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p[3:0]), .ent(ent), .enp(enp),
      .up(up), .q(q_bin), .rco(rco_bin), .wrap(wrap_bin), .sat(sat_bin));
   updn_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .RESET_VAL(3)) u_bsat (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p[3:0]), .ent(ent), .enp(enp),
      .up(up), .q(q_bsat), .rco(rco_bsat), .wrap(wrap_bsat), .sat(sat_bsat));
   updn_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .RESET_VAL(0)) u_b8 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p), .ent(ent), .enp(enp),
      .up(up), .q(q_b8), .rco(rco_b8), .wrap(wrap_b8), .sat(sat_b8));
   updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(5)) u_dsat (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .p(p[3:0]), .ent(ent), .enp(enp),
      .up(up), .q(q_dsat), .rco(rco_dsat), .wrap(wrap_dsat), .sat(sat_dsat));

   assign oq[0] = 32'(q_lo);   assign orc[0] = rco_lo;   assign ow[0] = wrap_lo;   assign os[0] = sat_lo;
   assign oq[1] = 32'(q_hi);   assign orc[1] = rco_hi;   assign ow[1] = wrap_hi;   assign os[1] = sat_hi;
   assign oq[2] = 32'(q_bin);  assign orc[2] = rco_bin;  assign ow[2] = wrap_bin;  assign os[2] = sat_bin;
   assign oq[3] = 32'(q_bsat); assign orc[3] = rco_bsat; assign ow[3] = wrap_bsat; assign os[3] = sat_bsat;
   assign oq[4] = 32'(q_b8);   assign orc[4] = rco_b8;   assign ow[4] = wrap_b8;   assign os[4] = sat_b8;
   assign oq[5] = 32'(q_dsat); assign orc[5] = rco_dsat; assign ow[5] = wrap_dsat; assign os[5] = sat_dsat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference behaviour: modular arithmetic on plain integers
   task automatic model_step(input int i, input bit r, input bit c, input bit l,
                             input int pv, input bit et, input bit ep, input bit u);
      int  m;
      int  pm;
      bit  at_end;
      m  = mod_a[i];
      pm = pv % (1 << wd_a[i]);
      if (r || c) begin
         mq[i] = rv_a[i]; mw[i] = 1'b0; ms[i] = 1'b0;
      end else if (l) begin
         mq[i] = (pm >= m) ? m - 1 : pm; mw[i] = 1'b0; ms[i] = 1'b0;
      end else if (et && ep) begin
         at_end = u ? (mq[i] == m - 1) : (mq[i] == 0);
         if (at_end && sm_a[i] == 1) begin
            mw[i] = 1'b0; ms[i] = 1'b1;
         end else begin
            mq[i] = (mq[i] + (u ? 1 : m - 1)) % m;
            mw[i] = at_end; ms[i] = 1'b0;
         end
      end else begin
         mw[i] = 1'b0;
      end
   endtask

   task automatic cycle(input bit r, input bit c, input bit l, input int pv,
                        input bit et, input bit ep, input bit u);
      bit ent_i [N];
      rst = r; clr = c; load = l; p = 8'(pv); ent = et; enp = ep; up = u;
      for (int i = 0; i < N; i++) begin
         ent_i[i]   = (i == 1) ? exp_rco[0] : et;
         exp_rco[i] = ent_i[i] && (u ? (mq[i] == mod_a[i] - 1) : (mq[i] == 0));
      end
      #1;
      if (mvalid)
         for (int i = 0; i < N; i++) check($sformatf("rco[%0d]", i), 32'(orc[i]), 32'(exp_rco[i]));
      @(posedge clk);
      for (int i = 0; i < N; i++) model_step(i, r, c, l, pv, ent_i[i], ep, u);
      mvalid = 1'b1;
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         check($sformatf("q[%0d]", i), oq[i], 32'(mq[i]));
         check($sformatf("wrap[%0d]", i), 32'(ow[i]), 32'(mw[i]));
         check($sformatf("sat[%0d]", i), 32'(os[i]), 32'(ms[i]));
      end
      $display("cyc %0d rst=%0b clr=%0b load=%0b p=%02h ent=%0b enp=%0b up=%0b q_lo=%0d q_hi=%0d q_b8=%0d",
               cyc, r, c, l, p, et, ep, u, q_lo, q_hi, q_b8);
   endtask

   initial begin
      int hi_wraps;
      for (int i = 0; i < N; i++) begin
         mq[i] = 0; mw[i] = 1'b0; ms[i] = 1'b0; exp_rco[i] = 1'b0;
      end
      @(posedge clk); #1;

      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 1);
      check("reset_q_bsat", oq[3], 32'd3);
      check("reset_q_dsat", oq[5], 32'd5);

      // Decade up count to 9, then wrap
      for (int k = 0; k < 9; k++) cycle(0, 0, 0, 0, 1, 1, 1);
      check("dec_at9", oq[0], 32'd9);
      ent = 1'b1; #1;
      check("rco_at9", 32'(rco_lo), 32'd1);
      cycle(0, 0, 0, 0, 1, 1, 1);
      check("dec_wrap_q", oq[0], 32'd0);
      check("dec_wrap_pulse", 32'(wrap_lo), 32'd1);
      cycle(0, 0, 0, 0, 0, 1, 1);
      check("dec_wrap_once", 32'(wrap_lo), 32'd0);

      // Clamped load, load with enables high
      cycle(0, 0, 1, 8'h0C, 1, 1, 1);
      check("load_clamp", oq[0], 32'd9);
      check("load_bin", oq[2], 32'd12);
      check("load_nowrap", 32'(wrap_lo), 32'd0);

      // Down from 0: binary wraps to 15, saturating holds and flags
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      check("bin_down_q", oq[2], 32'd15);
      check("bin_down_wrap", 32'(wrap_bin), 32'd1);
      check("bsat_down_q", oq[3], 32'd0);
      check("bsat_down_sat", 32'(sat_bsat), 32'd1);
      check("bsat_down_wrap", 32'(wrap_bsat), 32'd0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      check("bsat_sat_hold", 32'(sat_bsat), 32'd1);

      // Everything at once, then clr+load
      cycle(0, 0, 1, 5, 0, 0, 1);
      cycle(1, 1, 1, 7, 1, 1, 1);
      check("all_q_bsat", oq[3], 32'd3);
      check("all_q_lo", oq[0], 32'd0);
      cycle(0, 0, 1, 5, 0, 0, 1);
      cycle(0, 1, 1, 7, 1, 1, 1);
      check("clrload_q_dsat", oq[5], 32'd5);

      // 8-bit: at 255 counting with direction switched down
      cycle(0, 0, 1, 8'hFF, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 1, 0);
      check("b8_dir_q", oq[4], 32'd254);
      check("b8_dir_wrap", 32'(wrap_b8), 32'd0);

      // Two-digit cascade: 100 enables bring it back to 00
      cycle(1, 0, 0, 0, 0, 0, 1);
      hi_wraps = 0;
      for (int k = 0; k < 100; k++) begin
         cycle(0, 0, 0, 0, 1, 1, 1);
         if (wrap_hi) hi_wraps++;
      end
      check("casc_lo", oq[0], 32'd0);
      check("casc_hi", oq[1], 32'd0);
      check("casc_hi_wraps", 32'(hi_wraps), 32'd1);

      // Random traffic
      for (int k = 0; k < 2000; k++) begin
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 9) == 0), int'($urandom_range(0, 255)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 5) != 0) ^ (k[8]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_updn_counter

// File: doc/updn_counter.md
UPDN_COUNTER -- requirements
Module: updn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 Parameter MODULUS, default 2**WIDTH, count modulus: 10 gives decade, 2**WIDTH gives binary (legal range 2..2**WIDTH).
REQ-003 Parameter SATURATE, default 0; 0 = wrap at terminal count, 1 = hold at terminal count.
REQ-004 Parameter RESET_VAL, default 0, value q takes on reset/clear (must be < MODULUS).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all state changes on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clr  input  1  synchronous clear, active-high.
REQ-009 load  input  1  synchronous parallel load, active-high.
REQ-010 p  input  WIDTH  preset value for load.
REQ-011 ent  input  1  count enable T; also gates rco (cascade input).
REQ-012 enp  input  1  count enable P.
REQ-013 up  input  1  direction, 1 = up, 0 = down.
REQ-014 q  output  WIDTH  registered count.
REQ-015 rco  output  1  combinational ripple carry, for cascading.
REQ-016 wrap  output  1  registered one-cycle pulse, a wrap event occurred on the previous edge.
REQ-017 sat  output  1  registered flag, last enabled count was blocked by saturation.

Function
REQ-018 Edge priority SHALL be: rst > clr > load > count > hold.
REQ-019 Count SHALL occur only when ent & enp & ~load & ~clr.
REQ-020 Up count: q SHALL step q+1; at q == MODULUS-1, next q SHALL be 0 (SATURATE=0) or SHALL stay MODULUS-1 (SATURATE=1).
REQ-021 Down count: q SHALL step q-1; at q == 0, next q SHALL be MODULUS-1 (SATURATE=0) or SHALL stay 0 (SATURATE=1).
REQ-022 Terminal count tc SHALL be (up & q == MODULUS-1) | (~up & q == 0); rco SHALL be ent & tc, independent of enp and clk.
REQ-023 Load SHALL store p; p >= MODULUS SHALL be clamped to MODULUS-1.
REQ-024 clr SHALL set q to RESET_VAL, wrap to 0 and sat to 0.
REQ-025 wrap SHALL be 1 for exactly the cycle after a count that wrapped, otherwise 0; it SHALL never assert when SATURATE=1.
REQ-026 sat SHALL set on a count blocked at terminal count (SATURATE=1); it SHALL clear on the next executed step, load, clr or rst.
REQ-027 A direction change SHALL take effect on the same edge; up and down never conflict.
REQ-028 Arithmetic SHALL be WIDTH bits wide with no intermediate overflow; q SHALL never exceed MODULUS-1 after any edge.
REQ-029 load with ent & enp asserted SHALL load only; no count and no wrap pulse.

Reset
REQ-030 On rst, q = RESET_VAL, wrap = 0 and sat = 0 on the same edge, overriding every other input.
REQ-031 rst asserted mid-count SHALL discard any pending wrap pulse.
REQ-032 There SHALL be no asynchronous paths; rco is the only combinational output.

Structure
REQ-033 Package cnt_pkg SHALL hold the MODE_WRAP/MODE_SAT constants and the default modulus constants DECADE = 10 and BINARY4 = 16.
REQ-034 No sub-module; a single always block for state plus continuous assignments for tc/rco.
REQ-035 Cascading N counters SHALL use rco of stage k to drive ent of stage k+1, with enp common, giving a synchronous multi-digit counter.

Verification
REQ-036 WIDTH=4, MODULUS=10, up: count 0..9 -> q wraps 9->0, wrap=1 one cycle later, rco=1 only while q=9 and ent=1.
REQ-037 WIDTH=4, MODULUS=16, down from q=0 -> q=15, wrap pulse; with SATURATE=1 -> q stays 0, sat=1, wrap=0.
REQ-038 MODULUS=10, load p=4'hC -> q=9; load with ent=enp=1 -> q=p, no increment.
REQ-039 Simultaneous rst, clr, load and count at q=5 -> q=RESET_VAL, wrap=0, sat=0; clr+load -> q=RESET_VAL.
REQ-040 Two cascaded MODULUS=10 stages from 00, count 100 enables -> 00 again, with a high-digit wrap pulse exactly once.
REQ-041 WIDTH=8, MODULUS=256, up at 255 with up toggled to 0 on the same edge -> q=254, no wrap.
